// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle-latency instruction memory and
// presents {instr, pc, pc+4, valid} to decode with stall, flush and EBREAK halt.
module instr_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h00000000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_data,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_plus4,
    output logic                  o_valid,
    output logic                  o_halt
);

    localparam logic [DATA_WIDTH-1:0] EBREAK_INSTR = DATA_WIDTH'(32'h00100073);
    localparam logic [DATA_WIDTH-1:0] PC_STEP      = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK   = ~DATA_WIDTH'(3);

    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] d_pc_reg;
    logic                  d_valid_reg;
    logic [DATA_WIDTH-1:0] hold_instr_reg;
    logic                  hold_vld_reg;
    logic                  halted_reg;

    logic hold;
    logic ebreak_seen;

    assign hold        = i_stall | ~i_en;
    assign ebreak_seen = d_valid_reg && (o_instr == EBREAK_INSTR);

    assign o_imem_addr = pc_reg;
    assign o_instr     = !d_valid_reg ? NOP_INSTR :
                         hold_vld_reg ? hold_instr_reg : i_imem_data;
    assign o_pc        = d_pc_reg;
    assign o_pc_plus4  = d_pc_reg + PC_STEP;
    assign o_valid     = d_valid_reg;
    assign o_halt      = halted_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_reg         <= RESET_PC;
            d_pc_reg       <= RESET_PC;
            d_valid_reg    <= 1'b0;
            hold_instr_reg <= NOP_INSTR;
            hold_vld_reg   <= 1'b0;
            halted_reg     <= 1'b0;
        end else if (halted_reg) begin
            d_valid_reg  <= 1'b0;
            hold_vld_reg <= 1'b0;
        end else if (i_flush) begin
            pc_reg       <= i_redirect_pc & ALIGN_MASK;
            d_valid_reg  <= 1'b0;
            hold_vld_reg <= 1'b0;
        end else if (hold) begin
            // imem output moves on to mem[pc] during a stall, so latch the word for d_pc once
            if (!hold_vld_reg) begin
                hold_instr_reg <= i_imem_data;
                hold_vld_reg   <= 1'b1;
            end
        end else if (ebreak_seen) begin
            halted_reg   <= 1'b1;
            d_valid_reg  <= 1'b0;
            hold_vld_reg <= 1'b0;
        end else begin
            d_pc_reg     <= pc_reg;
            d_valid_reg  <= 1'b1;
            hold_vld_reg <= 1'b0;
            pc_reg       <= pc_reg + PC_STEP;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall/pause, flush, EBREAK
// halt, asynchronous reset and PC wrap-around with a high RESET_PC.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, stall, flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr, imem_data, instr, pc, pc_plus4;
    logic        valid, halt;

    logic [31:0] imem_addr2, imem_data2, instr2, pc2, pc_plus42;
    logic        valid2, halt2;

    logic [31:0] mem [0:63];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data  <= mem[imem_addr[7:2]];
    always @(posedge clk) imem_data2 <= {16'h2000, imem_addr2[15:0]};

    instr_fetch dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_stall(stall), .i_flush(flush),
        .i_redirect_pc(redirect_pc), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
        .o_instr(instr), .o_pc(pc), .o_pc_plus4(pc_plus4), .o_valid(valid), .o_halt(halt)
    );

    instr_fetch #(.RESET_PC(32'hFFFFFFF8)) dut_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1), .i_stall(1'b0), .i_flush(1'b0),
        .i_redirect_pc(32'h0), .o_imem_addr(imem_addr2), .i_imem_data(imem_data2),
        .o_instr(instr2), .o_pc(pc2), .o_pc_plus4(pc_plus42), .o_valid(valid2), .o_halt(halt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
        $display("[TB] %-14s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic e_valid);
        check({tag, "_valid"}, {31'b0, valid}, {31'b0, e_valid});
        check({tag, "_instr"}, instr, e_instr);
        if (e_valid) begin
            check({tag, "_pc"}, pc, e_pc);
            check({tag, "_pc4"}, pc_plus4, e_pc + 32'd4);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"}, imem_addr, 32'h0);
        check({tag, "_instr"}, instr, 32'h13);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_pc4"}, pc_plus4, 32'h4);
        check({tag, "_valid"}, {31'b0, valid}, 32'h0);
        check({tag, "_halt"}, {31'b0, halt}, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] wrap_pc [0:2];
        logic [31:0] wrap_p4 [0:2];
        wrap_pc[0] = 32'hFFFFFFF8; wrap_pc[1] = 32'hFFFFFFFC; wrap_pc[2] = 32'h00000000;
        wrap_p4[0] = 32'hFFFFFFFC; wrap_p4[1] = 32'h00000000; wrap_p4[2] = 32'h00000004;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        rst_n = 1'b0; en = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        #1;
        check_reset("rst");
        step();
        rst_n = 1'b1;

        // sequential fetch with wrap-around on the second instance
        check("first_valid", {31'b0, valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("seq", 32'(4 * k), 32'h1000_0000 + 32'(k), 1'b1);
            check("wrap_pc", pc2, wrap_pc[k]);
            check("wrap_pc4", pc_plus42, wrap_p4[k]);
            check("wrap_instr", instr2, {16'h2000, wrap_pc[k][15:0]});
        end

        // hazard stall, then debug pause
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("stall", 32'h8, 32'h1000_0002, 1'b1);
        end
        stall = 1'b0;
        step();
        check_out("stall_rel", 32'hC, 32'h1000_0003, 1'b1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_out("pause", 32'hC, 32'h1000_0003, 1'b1);
        end
        en = 1'b1;
        step();
        check_out("pause_rel", 32'h10, 32'h1000_0004, 1'b1);

        // flush wins over simultaneous stall; low address bits dropped
        flush = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        check("flush_addr", imem_addr, 32'h40);
        check_out("flush_bub", 32'h0, 32'h13, 1'b0);
        step();
        check_out("flush_tgt", 32'h40, 32'h1000_0010, 1'b1);

        // async reset in the middle of a stall with the hold register loaded
        stall = 1'b1;
        step();
        check_out("pre_rst", 32'h40, 32'h1000_0010, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        stall = 1'b0;
        mem[4] = 32'h0010_0073;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("restart_vld", {31'b0, valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_out("restart", 32'(4 * k), 32'h1000_0000 + 32'(k), 1'b1);
        end

        // EBREAK halts fetch; later flush ignored
        step();
        check_out("ebreak", 32'h10, 32'h0010_0073, 1'b1);
        check("ebreak_addr", imem_addr, 32'h14);
        step();
        check("halt", {31'b0, halt}, 32'h1);
        check("halt_valid", {31'b0, valid}, 32'h0);
        check("halt_addr", imem_addr, 32'h14);
        check("halt_instr", instr, 32'h13);
        flush = 1'b1; redirect_pc = 32'h80;
        step();
        flush = 1'b0;
        check("halt_flush", imem_addr, 32'h14);
        check("halt_sticky", {31'b0, halt}, 32'h1);

        // flush in the same cycle as EBREAK on the output: no halt
        do_reset();
        for (int k = 0; k < 5; k++) step();
        check_out("eb2", 32'h10, 32'h0010_0073, 1'b1);
        flush = 1'b1; redirect_pc = 32'h20;
        step();
        flush = 1'b0;
        check("eb2_nohalt", {31'b0, halt}, 32'h0);
        check("eb2_addr", imem_addr, 32'h20);
        check("eb2_valid", {31'b0, valid}, 32'h0);
        step();
        check_out("eb2_tgt", 32'h20, 32'h1000_0008, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
